// File: rtl/data_axi_bridge.sv
// -----------------------------------------------------------------------------
// data_axi_bridge
//
// Bridges a simple CPU data-side request interface (req/addr_ok/data_ok) onto
// a 32-bit AXI master. Only one transaction is in flight at any time: a
// request is accepted in IDLE, its address/data/strobe are latched, the
// matching AXI channels are driven, and the block returns to IDLE once the
// read data or write response has been consumed.
//
// Optional feature (compile-time macro):
//   DATA_AXI_BRIDGE_EARLY_WACK_EN
//     When defined, a write reports completion (data_ok) in the cycle in
//     which the last of the AW/W handshakes completes. The B response is
//     still consumed in WR_RESP, but it produces no second pulse. When the
//     macro is not defined, a write completes in the bvalid cycle.
//
// Ports
//   clk      in   1   single clock, rising edge
//   resetn   in   1   synchronous, active-low reset
//   req      in   1   CPU request valid
//   wr       in   1   1 = write, 0 = read
//   wstrb    in   4   write byte enables
//   addr     in  32   byte address
//   wdata    in  32   write data
//   addr_ok  out  1   request accepted this cycle when req & addr_ok
//   data_ok  out  1   one-cycle completion pulse
//   rdata    out 32   read data, meaningful only with data_ok on a read
//   araddr   out 32   AXI AR address       arvalid out 1 / arready in 1
//   r_data   in  32   AXI R data           rvalid  in  1 / rready  out 1
//   awaddr   out 32   AXI AW address       awvalid out 1 / awready in 1
//   w_data   out 32   AXI W data
//   w_strb   out  4   AXI W strobes        wvalid  out 1 / wready  in 1
//   bvalid   in   1   AXI B response valid bready  out 1
// -----------------------------------------------------------------------------
module data_axi_bridge (
    input  logic        clk,
    input  logic        resetn,
    // CPU side
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    // AXI read address
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data
    input  logic [31:0] r_data,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data
    output logic [31:0] w_data,
    output logic [3:0]  w_strb,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic        bvalid,
    output logic        bready
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR_ADDR = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;

    logic [2:0]  state_reg;
    logic [2:0]  state_next;

    // Request capture registers
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic        wr_reg;

    // Per-channel completion flags for the write address/data handshakes
    logic        aw_done_reg;
    logic        aw_done_next;
    logic        w_done_reg;
    logic        w_done_next;

    // -------------------------------------------------------------------------
    // Decoded state and handshake terms
    // -------------------------------------------------------------------------
    logic        in_idle;
    logic        in_rd_addr;
    logic        in_rd_data;
    logic        in_wr_addr;
    logic        in_wr_resp;

    logic        accept;      // CPU request taken this cycle
    logic        aw_hs;       // AW handshake this cycle
    logic        w_hs;        // W handshake this cycle
    logic        aw_fin;      // AW complete, now or earlier
    logic        w_fin;       // W complete, now or earlier
    logic        wr_issue_done; // last of AW/W completes this cycle
    logic        rd_done;     // read data consumed this cycle
    logic        wr_ack;      // write completion reported this cycle

    assign in_idle    = (state_reg == ST_IDLE);
    assign in_rd_addr = (state_reg == ST_RD_ADDR);
    assign in_rd_data = (state_reg == ST_RD_DATA);
    assign in_wr_addr = (state_reg == ST_WR_ADDR);
    assign in_wr_resp = (state_reg == ST_WR_RESP);

    assign accept = req && in_idle;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign aw_fin = aw_done_reg || aw_hs;
    assign w_fin  = w_done_reg || w_hs;

    // Both write-side handshakes are finished, whichever order they came in.
    assign wr_issue_done = in_wr_addr && aw_fin && w_fin;

    assign rd_done = in_rd_data && rvalid;

`ifdef DATA_AXI_BRIDGE_EARLY_WACK_EN
    // Early acknowledge: complete the CPU write as soon as the AXI slave
    // has taken both address and data; B is drained silently afterwards.
    assign wr_ack = wr_issue_done;
`else
    // Completion waits for the write response.
    assign wr_ack = in_wr_resp && bvalid;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    state_next   = wr ? ST_WR_ADDR : ST_RD_ADDR;
                end
            end

            ST_RD_ADDR: begin
                if (arready) begin
                    state_next = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                if (rvalid) begin
                    state_next = ST_IDLE;
                end
            end

            ST_WR_ADDR: begin
                // Remember each handshake so its valid drops independently.
                aw_done_next = aw_fin;
                w_done_next  = w_fin;
                if (aw_fin && w_fin) begin
                    // Flags are cleared on exit so the next write starts fresh.
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    state_next   = ST_WR_RESP;
                end
            end

            ST_WR_RESP: begin
                if (bvalid) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next   = ST_IDLE;
                aw_done_next = 1'b0;
                w_done_next  = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and flag registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg   <= ST_IDLE;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
        end
    end

    // -------------------------------------------------------------------------
    // Request capture. Values are held for the whole transaction so that
    // AXI address/data stay stable while valid is waiting for ready.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_reg  <= 32'h0;
            wdata_reg <= 32'h0;
            wstrb_reg <= 4'h0;
            wr_reg    <= 1'b0;
        end else if (accept) begin
            addr_reg  <= addr;
            wdata_reg <= wdata;
            wstrb_reg <= wstrb;
            wr_reg    <= wr;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Valids are pure functions of registered state, so they cannot
    // change while waiting for ready; payloads come straight from the capture
    // registers for the same reason.
    // -------------------------------------------------------------------------
    assign addr_ok = in_idle;

    assign araddr  = addr_reg;
    assign arvalid = in_rd_addr;

    assign rready  = in_rd_data;

    assign awaddr  = addr_reg;
    assign awvalid = in_wr_addr && !aw_done_reg;

    assign w_data  = wdata_reg;
    assign w_strb  = wstrb_reg;
    assign wvalid  = in_wr_addr && !w_done_reg;

    assign bready  = in_wr_resp;

    assign data_ok = rd_done || wr_ack;

    // Read data is passed through in the rvalid cycle; zero otherwise so the
    // bus is quiet outside a read completion.
    assign rdata   = (rd_done && !wr_reg) ? r_data : 32'h0;

endmodule

// File: tb/tb_data_axi_bridge.sv
// -----------------------------------------------------------------------------
// tb_data_axi_bridge
//
// Directed bench for data_axi_bridge. The stimulus process drives the CPU and
// AXI-slave inputs cycle by cycle and, whenever it issues a request, pushes
// the expected completion (cycle number and read data) into a queue. A
// separate monitor pops that queue on every data_ok and compares. The
// stimulus process additionally checks the AXI channel outputs inline.
// Define DATA_AXI_BRIDGE_EARLY_WACK_EN to check the early-acknowledge build.
// -----------------------------------------------------------------------------
module tb_data_axi_bridge;

    logic        clk;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] r_data;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    data_axi_bridge dut (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .wr      (wr),
        .wstrb   (wstrb),
        .addr    (addr),
        .wdata   (wdata),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .r_data  (r_data),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .w_data  (w_data),
        .w_strb  (w_strb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle index; a "cycle" spans posedge to posedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        is_rd;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_done(input logic is_rd, input logic [31:0] rd, input int at);
        exp_t e;
        e.is_rd = is_rd;
        e.rdata = rd;
        e.cyc   = at;
        exp_q.push_back(e);
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every data_ok must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (data_ok === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_data_ok: got data_ok=1, expected 0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("data_ok_cycle", cyc, e.cyc);
                if (e.is_rd) check("rdata", rdata, e.rdata);
                $display("data_ok at cycle %0d rd=%0b rdata=0x%08h", cyc, e.is_rd, rdata);
            end
        end
    end

    int c0;
    int wr_done_ofs;

    initial begin
        resetn  = 1'b0;
        req     = 1'b0;
        wr      = 1'b0;
        wstrb   = 4'h0;
        addr    = 32'h0;
        wdata   = 32'h0;
        arready = 1'b0;
        r_data  = 32'h0;
        rvalid  = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;

        // ---------------- Reset state ----------------
        step();
        step();
        @(negedge clk);
        check("rst_addr_ok", addr_ok, 1);
        check("rst_data_ok", data_ok, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid",  wvalid,  0);
        check("rst_rready",  rready,  0);
        check("rst_bready",  bready,  0);
        check("rst_araddr",  araddr,  0);
        check("rst_w_data",  w_data,  0);
        check("rst_w_strb",  w_strb,  0);
        check("rst_rdata",   rdata,   0);
        step();
        resetn = 1'b1;
        step();

        // ---------------- Minimum-latency read ----------------
        arready = 1'b1;
        req = 1'b1; wr = 1'b0; addr = 32'h1C00_0010;
        @(negedge clk);
        check("rd1_accept", addr_ok, 1);
        c0 = cyc;
        expect_done(1'b1, 32'hDEAD_BEEF, c0 + 2);
        $display("read  addr=0x1C000010 accepted at cycle %0d", c0);
        step();
        req = 1'b0; addr = 32'h0;
        @(negedge clk);
        check("rd1_arvalid", arvalid, 1);
        check("rd1_araddr",  araddr, 32'h1C00_0010);
        check("rd1_busy",    addr_ok, 0);
        step();
        rvalid = 1'b1; r_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rd1_rready",  rready, 1);
        check("rd1_arvalid_lo", arvalid, 0);
        step();
        rvalid = 1'b0; r_data = 32'h0;
        @(negedge clk);
        check("rd1_idle", addr_ok, 1);
        step();

        // ---------------- Write, AW delayed, W immediate ----------------
`ifdef DATA_AXI_BRIDGE_EARLY_WACK_EN
        wr_done_ofs = 3;
`else
        wr_done_ofs = 4;
`endif
        arready = 1'b0;
        awready = 1'b0; wready = 1'b1;
        req = 1'b1; wr = 1'b1; addr = 32'h8; wdata = 32'h1234_5678; wstrb = 4'h3;
        @(negedge clk);
        check("wr1_accept", addr_ok, 1);
        c0 = cyc;
        expect_done(1'b0, 32'h0, c0 + wr_done_ofs);
        $display("write addr=0x00000008 accepted at cycle %0d", c0);
        step();
        req = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
        @(negedge clk);
        check("wr1_awvalid_c1", awvalid, 1);
        check("wr1_wvalid_c1",  wvalid, 1);
        check("wr1_awaddr_c1",  awaddr, 32'h8);
        check("wr1_w_data",     w_data, 32'h1234_5678);
        check("wr1_w_strb",     w_strb, 4'h3);
        step();
        @(negedge clk);
        check("wr1_wvalid_c2",  wvalid, 0);
        check("wr1_awvalid_c2", awvalid, 1);
        check("wr1_awaddr_c2",  awaddr, 32'h8);
        check("wr1_busy_c2",    addr_ok, 0);
        step();
        awready = 1'b1;
        @(negedge clk);
        check("wr1_awvalid_c3", awvalid, 1);
        check("wr1_awaddr_c3",  awaddr, 32'h8);
        check("wr1_bready_c3",  bready, 0);
        step();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        @(negedge clk);
        check("wr1_awvalid_c4", awvalid, 0);
        check("wr1_bready_c4",  bready, 1);
        check("wr1_busy_c4",    addr_ok, 0);
        step();
        bvalid = 1'b0;
        @(negedge clk);
        check("wr1_idle", addr_ok, 1);
        step();

        // ---------------- Read with AR stalled for 5 cycles ----------------
        arready = 1'b0;
        req = 1'b1; wr = 1'b0; addr = 32'h2000_0040;
        @(negedge clk);
        check("rd2_accept", addr_ok, 1);
        c0 = cyc;
        expect_done(1'b1, 32'hCAFE_F00D, c0 + 7);
        $display("read  addr=0x20000040 accepted at cycle %0d", c0);
        step();
        addr = 32'h5555_0000;   // a second request is waiting and must be ignored
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rd2_arvalid_stall", arvalid, 1);
            check("rd2_araddr_stall",  araddr, 32'h2000_0040);
            check("rd2_addr_ok_stall", addr_ok, 0);
            step();
        end
        req = 1'b0; addr = 32'h0; arready = 1'b1;
        @(negedge clk);
        check("rd2_arvalid_hs", arvalid, 1);
        step();
        arready = 1'b0; rvalid = 1'b1; r_data = 32'hCAFE_F00D;
        @(negedge clk);
        check("rd2_rready", rready, 1);
        step();
        rvalid = 1'b0; r_data = 32'h0;
        @(negedge clk);
        check("rd2_idle", addr_ok, 1);
        step();

        // ---------------- Reset while in RD_DATA ----------------
        arready = 1'b1;
        req = 1'b1; wr = 1'b0; addr = 32'h3000_0000;
        @(negedge clk);
        check("rd3_accept", addr_ok, 1);
        $display("read  addr=0x30000000 accepted at cycle %0d (aborted by reset)", cyc);
        step();
        req = 1'b0; addr = 32'h0;
        @(negedge clk);
        check("rd3_arvalid", arvalid, 1);
        step();
        resetn = 1'b0;
        @(negedge clk);
        check("rd3_rready_before_rst", rready, 1);
        step();
        resetn = 1'b1; rvalid = 1'b1; r_data = 32'hBAD0_BAD0; bvalid = 1'b1;
        @(negedge clk);
        check("rd3_rready_after_rst", rready, 0);
        check("rd3_addr_ok_after_rst", addr_ok, 1);
        check("rd3_no_data_ok", data_ok, 0);
        check("rd3_stray_bready", bready, 0);
        check("rd3_araddr_cleared", araddr, 0);
        step();
        rvalid = 1'b0; r_data = 32'h0; bvalid = 1'b0; arready = 1'b0;
        step();

        // ---------------- Write, AW and W together, slow B ----------------
        awready = 1'b1; wready = 1'b1;
        req = 1'b1; wr = 1'b1; addr = 32'h40; wdata = 32'hA5A5_5A5A; wstrb = 4'hF;
        @(negedge clk);
        check("wr2_accept", addr_ok, 1);
        c0 = cyc;
`ifdef DATA_AXI_BRIDGE_EARLY_WACK_EN
        expect_done(1'b0, 32'h0, c0 + 1);
`else
        expect_done(1'b0, 32'h0, c0 + 4);
`endif
        $display("write addr=0x00000040 accepted at cycle %0d", c0);
        step();
        req = 1'b0; wr = 1'b0;
        @(negedge clk);
        check("wr2_awvalid", awvalid, 1);
        check("wr2_wvalid",  wvalid, 1);
        step();
        awready = 1'b0; wready = 1'b0;
        @(negedge clk);
        check("wr2_bready_c2", bready, 1);
        check("wr2_busy_c2",   addr_ok, 0);
        check("wr2_valids_lo", {30'h0, awvalid, wvalid}, 0);
        step();
        @(negedge clk);
        check("wr2_busy_c3", addr_ok, 0);
        step();
        bvalid = 1'b1;
        @(negedge clk);
        check("wr2_bready_c4", bready, 1);
        step();
        bvalid = 1'b0;
        @(negedge clk);
        check("wr2_idle", addr_ok, 1);
        step();

        // ---------------- Write, W delayed, B waiting early ----------------
        awready = 1'b1; wready = 1'b0; bvalid = 1'b1;
        req = 1'b1; wr = 1'b1; addr = 32'h0000_0104; wdata = 32'h0BAD_F00D; wstrb = 4'hC;
        @(negedge clk);
        check("wr3_accept", addr_ok, 1);
        c0 = cyc;
        expect_done(1'b0, 32'h0, c0 + wr_done_ofs);
        $display("write addr=0x00000104 accepted at cycle %0d", c0);
        step();
        req = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
        @(negedge clk);
        check("wr3_awvalid_c1", awvalid, 1);
        check("wr3_wvalid_c1",  wvalid, 1);
        check("wr3_bready_c1",  bready, 0);
        step();
        @(negedge clk);
        check("wr3_awvalid_c2", awvalid, 0);
        check("wr3_wvalid_c2",  wvalid, 1);
        check("wr3_w_data_c2",  w_data, 32'h0BAD_F00D);
        check("wr3_bready_c2",  bready, 0);
        step();
        wready = 1'b1;
        @(negedge clk);
        check("wr3_wvalid_c3", wvalid, 1);
        check("wr3_w_strb_c3", w_strb, 4'hC);
        step();
        awready = 1'b0; wready = 1'b0;
        @(negedge clk);
        check("wr3_bready_c4", bready, 1);
        step();
        bvalid = 1'b0;
        @(negedge clk);
        check("wr3_idle", addr_ok, 1);
        step();

        // Drain and final scoreboard check
        step();
        step();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_axi_bridge.md
DATA_AXI_BRIDGE -- requirements
Module: data_axi_bridge

Interface
- REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit address/data and 4-bit strobe.
- REQ-002 clk  in  1  single clock; all state SHALL change on the rising edge.
- REQ-003 resetn  in  1  reset, synchronous and active-low.
- REQ-004 req  in  1  CPU data request valid.
- REQ-005 wr  in  1  1 = write, 0 = read.
- REQ-006 wstrb  in  4  write byte enables.
- REQ-007 addr  in  32  byte address.
- REQ-008 wdata  in  32  write data.
- REQ-009 addr_ok  out  1  request accepted this cycle when req&addr_ok.
- REQ-010 data_ok  out  1  one-cycle completion pulse.
- REQ-011 rdata  out  32  read data, valid only when data_ok is high for a read.
- REQ-012 araddr/arvalid  out  32/1  AXI read-address channel; arready  in  1.
- REQ-013 r_data/rvalid  in  32/1  AXI read-data channel; rready  out  1.
- REQ-014 awaddr/awvalid  out  32/1  AXI write-address channel; awready  in  1.
- REQ-015 w_data/w_strb/wvalid  out  32/4/1  AXI write-data channel; wready  in  1.
- REQ-016 bvalid  in  1  AXI write response; bready  out  1.

Function
- REQ-017 The FSM SHALL have five states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, with at most one outstanding transaction.
- REQ-018 addr_ok SHALL be 1 only in IDLE; on req&addr_ok the block SHALL register addr, wr, wstrb and wdata, then go to RD_ADDR if wr=0 or WR_ADDR if wr=1.
- REQ-019 RD_ADDR: arvalid=1 and araddr=latched addr, held stable until arready; on arready the FSM SHALL go to RD_DATA.
- REQ-020 RD_DATA: rready=1; on rvalid the block SHALL drive data_ok=1 and rdata=r_data in the same cycle, then return to IDLE.
- REQ-021 WR_ADDR: awvalid and wvalid SHALL rise together.
  - Each SHALL drop independently after its own handshake, tracked by aw_done/w_done flags.
  - When both handshakes have completed (same or different cycles), the FSM SHALL go to WR_RESP.
- REQ-022 WR_RESP: bready=1; on bvalid the FSM SHALL return to IDLE.
- REQ-023 Write completion: data_ok SHALL pulse in the bvalid cycle (see REQ-030 for the early-ack variant).
- REQ-024 Minimum latency: if arready and rvalid are both already high, a read accepted in cycle 0 SHALL see arvalid in cycle 1 and data_ok in cycle 2.
- REQ-025 Valid and data outputs SHALL NOT change while their valid is high and ready is low.
- REQ-026 The next request SHALL be accepted no earlier than the cycle after the return to IDLE; back-to-back requests never overlap.
- REQ-027 rvalid/bvalid received in any state other than RD_DATA/WR_RESP SHALL be ignored (rready/bready=0).

Reset
- REQ-028 With resetn=0 at a clock edge, the block SHALL enter IDLE and clear aw_done/w_done. All outputs SHALL be 0 except addr_ok=1; this applies mid-transaction too, abandoning that transaction.
- REQ-029 The latched addr/wdata/wstrb registers SHALL reset to 0.

Configuration
- REQ-030 With macro DATA_AXI_BRIDGE_EARLY_WACK_EN defined:
  - Write data_ok SHALL pulse in the cycle the last of the aw/w handshakes completes.
  - bvalid SHALL still be consumed in WR_RESP without a second pulse.
  - addr_ok SHALL stay 0 until the return to IDLE.
  - Without the macro, REQ-023 applies.

Verification
- REQ-031 Read addr=0x1C00_0010, arready=1, rvalid with r_data=0xDEAD_BEEF in cycle 2 -> data_ok=1 and rdata=0xDEAD_BEEF in cycle 2; addr_ok=1 in cycle 3.
- REQ-032 Write addr=0x8, wdata=0x1234_5678, wstrb=0x3, awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle; awvalid held 3 cycles with awaddr stable; data_ok on the bvalid cycle.
- REQ-033 Read with arready=0 for 5 cycles -> arvalid and araddr stable for 5 cycles; req ignored (addr_ok=0) throughout.
- REQ-034 resetn=0 while in RD_DATA -> next cycle IDLE, rready=0, addr_ok=1; a late rvalid produces no data_ok.
- REQ-035 With DATA_AXI_BRIDGE_EARLY_WACK_EN, aw/w handshakes in cycle 1 and bvalid in cycle 4 -> data_ok in cycle 1 only; addr_ok=1 from cycle 5.
